// File: rtl/lif_wta_pkg.sv
// Shared widths, arbitration mode encodings and saturating helpers for the
// leaky integrate-and-fire winner-take-all array.
package lif_wta_pkg;

  localparam int DEF_N_NEURONS = 4;
  localparam int DEF_STATE_W   = 8;
  localparam int DEF_CUR_W     = 4;
  localparam int DEF_REFRAC_W  = 3;

  // Arbitration mode encodings, matching the rr_mode pin.
  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

  // Unsigned add, clamped to the largest value that fits in w bits.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] max_v;
    sum   = {1'b0, a} + {1'b0, b};
    max_v = (33'd1 << w) - 33'd1;
    return (sum > max_v) ? max_v[31:0] : sum[31:0];
  endfunction

  // Unsigned subtract, clamped at zero instead of wrapping.
  function automatic logic [31:0] sat_sub0(input logic [31:0] a,
                                           input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/lif_neuron_core.sv
// One leaky integrate-and-fire neuron: membrane state, refractory counter,
// candidate detection and the win / inhibit / integrate update.
module lif_neuron_core
  import lif_wta_pkg::*;
#(
  parameter int STATE_W  = DEF_STATE_W,
  parameter int CUR_W    = DEF_CUR_W,
  parameter int REFRAC_W = DEF_REFRAC_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [CUR_W-1:0]    current,
  input  logic [STATE_W-1:0]  threshold,
  input  logic [STATE_W-1:0]  leak,
  input  logic [STATE_W-1:0]  inhib_amt,
  input  logic                hard_inhib,
  input  logic [REFRAC_W-1:0] refrac_len,
  input  logic                win,
  input  logic                any_win,
  output logic                cand,
  output logic                state_msb
);

  logic [STATE_W-1:0]  state_q, state_d;
  logic [REFRAC_W-1:0] refrac_q, refrac_d;
  logic [STATE_W-1:0]  cand_state;
  logic [STATE_W-1:0]  inhibited;
  logic [31:0]         leaked_w;
  logic [31:0]         sum_w;
  logic [31:0]         inhib_w;

  // Narrow a 32-bit helper result back to the state width, clamping high.
  function automatic logic [STATE_W-1:0] fit(input logic [31:0] v);
    return (|(v >> STATE_W)) ? '1 : v[STATE_W-1:0];
  endfunction

  // Leak, integrate and compare against the shared threshold.
  always_comb begin
    leaked_w   = sat_sub0(32'(state_q), 32'(leak));
    sum_w      = sat_add(leaked_w, 32'(current), STATE_W);
    cand_state = fit(sum_w);
    inhib_w    = sat_sub0(32'(cand_state), 32'(inhib_amt));
    inhibited  = fit(inhib_w);
    cand       = (refrac_q == '0) && (cand_state >= threshold);
  end

  // Next state: refractory hold, win reset, lateral inhibition or integrate.
  always_comb begin
    state_d  = state_q;
    refrac_d = refrac_q;
    if (en) begin
      if (refrac_q != '0) begin
        refrac_d = refrac_q - REFRAC_W'(1);
        state_d  = '0;
      end else if (win) begin
        state_d  = '0;
        refrac_d = refrac_len;
      end else if (any_win) begin
        state_d  = hard_inhib ? '0 : inhibited;
      end else begin
        state_d  = cand_state;
      end
    end
  end

  // Membrane and refractory registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= '0;
      refrac_q <= '0;
    end else begin
      state_q  <= state_d;
      refrac_q <= refrac_d;
    end
  end

  assign state_msb = state_q[STATE_W-1];

endmodule

// File: rtl/lif_wta_array.sv
// Winner-take-all array of N LIF neurons with fixed-priority or round-robin
// resolution of simultaneous threshold crossings and a registered one-hot spike.
module lif_wta_array
  import lif_wta_pkg::*;
#(
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int STATE_W   = DEF_STATE_W,
  parameter int CUR_W     = DEF_CUR_W,
  parameter int REFRAC_W  = DEF_REFRAC_W,
  parameter int IDX_W     = $clog2(N_NEURONS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [N_NEURONS*CUR_W-1:0]   current,
  input  logic [STATE_W-1:0]           threshold,
  input  logic [STATE_W-1:0]           leak,
  input  logic [STATE_W-1:0]           inhib_amt,
  input  logic                         hard_inhib,
  input  logic                         rr_mode,
  input  logic [REFRAC_W-1:0]          refrac_len,
  output logic [N_NEURONS-1:0]         spike,
  output logic [IDX_W-1:0]             winner_idx,
  output logic                         winner_valid,
  output logic [N_NEURONS-1:0]         state_msb
);

  logic [N_NEURONS-1:0] cand;
  logic [N_NEURONS-1:0] win_onehot;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     ptr_next;
  logic                 found;
  logic                 any_win;

  logic [N_NEURONS-1:0] spike_q, spike_d;
  logic [IDX_W-1:0]     winner_idx_q, winner_idx_d;
  logic                 winner_valid_q, winner_valid_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;

  for (genvar g = 0; g < N_NEURONS; g++) begin : g_neuron
    lif_neuron_core #(
      .STATE_W  (STATE_W),
      .CUR_W    (CUR_W),
      .REFRAC_W (REFRAC_W)
    ) u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .current    (current[g*CUR_W +: CUR_W]),
      .threshold  (threshold),
      .leak       (leak),
      .inhib_amt  (inhib_amt),
      .hard_inhib (hard_inhib),
      .refrac_len (refrac_len),
      .win        (win_onehot[g]),
      .any_win    (any_win),
      .cand       (cand[g]),
      .state_msb  (state_msb[g])
    );
  end

  // Pick one winner among the candidates: lowest index, or first at/after the pointer.
  always_comb begin
    int j;
    logic [IDX_W-1:0] j_idx;
    found = 1'b0;
    win_idx = '0;
    j = 0;
    j_idx = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      if (rr_mode == ARB_RR) begin
        j = int'(rr_ptr_q) + k;
        if (j >= N_NEURONS) j = j - N_NEURONS;
      end else begin
        j = k;
      end
      j_idx = IDX_W'(j);
      if (!found && cand[j_idx]) begin
        found   = 1'b1;
        win_idx = j_idx;
      end
    end
    any_win    = found && en;
    win_onehot = any_win ? (N_NEURONS'(1) << win_idx) : '0;
    ptr_next   = (win_idx == IDX_W'(N_NEURONS - 1)) ? '0 : win_idx + IDX_W'(1);
  end

  // Output and pointer next-state; the pointer moves only when someone wins.
  always_comb begin
    spike_d        = win_onehot;
    winner_valid_d = any_win;
    winner_idx_d   = any_win ? win_idx : winner_idx_q;
    rr_ptr_d       = any_win ? ptr_next : rr_ptr_q;
  end

  // Registered spike, winner report and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q        <= '0;
      winner_idx_q   <= '0;
      winner_valid_q <= 1'b0;
      rr_ptr_q       <= '0;
    end else begin
      spike_q        <= spike_d;
      winner_idx_q   <= winner_idx_d;
      winner_valid_q <= winner_valid_d;
      rr_ptr_q       <= rr_ptr_d;
    end
  end

  assign spike        = spike_q;
  assign winner_idx   = winner_idx_q;
  assign winner_valid = winner_valid_q;

endmodule

// File: tb/tb_lif_wta_array.sv
// Scoreboard bench for lif_wta_array: a behavioural model predicts each edge's
// outputs, the prediction is queued when inputs are driven and popped after the edge.
module tb_lif_wta_array;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [15:0]  current = '0;
  logic [7:0]   threshold = '0;
  logic [7:0]   leak = '0;
  logic [7:0]   inhib_amt = '0;
  logic         hard_inhib = 1'b0;
  logic         rr_mode = 1'b0;
  logic [2:0]   refrac_len = '0;
  logic [3:0]   spike;
  logic [1:0]   winner_idx;
  logic         winner_valid;
  logic [3:0]   state_msb;

  typedef struct packed {
    logic [3:0] spike;
    logic [1:0] idx;
    logic       valid;
    logic [3:0] msb;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int m_state[N];
  int m_refrac[N];
  int m_ptr;
  int m_idx;

  lif_wta_array dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .current      (current),
    .threshold    (threshold),
    .leak         (leak),
    .inhib_amt    (inhib_amt),
    .hard_inhib   (hard_inhib),
    .rr_mode      (rr_mode),
    .refrac_len   (refrac_len),
    .spike        (spike),
    .winner_idx   (winner_idx),
    .winner_valid (winner_valid),
    .state_msb    (state_msb)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i]  = 0;
      m_refrac[i] = 0;
    end
    m_ptr = 0;
    m_idx = 0;
  endtask

  // Predict the outputs after the next edge from the present inputs.
  task automatic model_eval(output exp_t e);
    int cs[N];
    bit cd[N];
    int w;
    int t;
    int j;
    e = '0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        cs[i] = 0;
        cd[i] = 1'b0;
        if (m_refrac[i] == 0) begin
          t = m_state[i] - int'(leak);
          if (t < 0) t = 0;
          t = t + int'(current[i*4 +: 4]);
          if (t > 255) t = 255;
          cs[i] = t;
          cd[i] = (t >= int'(threshold));
        end
      end
      w = -1;
      for (int k = 0; k < N; k++) begin
        j = rr_mode ? (m_ptr + k) % N : k;
        if (w < 0 && cd[j]) w = j;
      end
      for (int i = 0; i < N; i++) begin
        if (m_refrac[i] != 0) begin
          m_refrac[i]--;
          m_state[i] = 0;
        end else if (i == w) begin
          m_state[i]  = 0;
          m_refrac[i] = int'(refrac_len);
        end else if (w >= 0) begin
          t = cs[i] - int'(inhib_amt);
          m_state[i] = hard_inhib ? 0 : ((t < 0) ? 0 : t);
        end else begin
          m_state[i] = cs[i];
        end
      end
      if (w >= 0) begin
        m_ptr      = (w + 1) % N;
        m_idx      = w;
        e.spike[w] = 1'b1;
        e.valid    = 1'b1;
      end
    end
    e.idx = 2'(m_idx);
    for (int i = 0; i < N; i++) e.msb[i] = (m_state[i] >= 128);
  endtask

  // Drive one edge: queue the prediction, clock, then compare after the edge.
  task automatic step(input string tag);
    exp_t e;
    exp_t got;
    model_eval(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check_eq({tag, "_spike"}, 32'(spike), 32'(got.spike));
    check_eq({tag, "_valid"}, 32'(winner_valid), 32'(got.valid));
    check_eq({tag, "_idx"}, 32'(winner_idx), 32'(got.idx));
    check_eq({tag, "_msb"}, 32'(state_msb), 32'(got.msb));
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic set_cur(input int c0, input int c1, input int c2, input int c3);
    current = {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    en         = 1'b0;
    current    = '0;
    threshold  = '0;
    leak       = '0;
    inhib_amt  = '0;
    hard_inhib = 1'b0;
    rr_mode    = 1'b0;
    refrac_len = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    do_reset();
    check_eq("rst_spike", 32'(spike), 32'd0);
    check_eq("rst_valid", 32'(winner_valid), 32'd0);
    check_eq("rst_idx", 32'(winner_idx), 32'd0);
    check_eq("rst_msb", 32'(state_msb), 32'd0);

    // Integrate 3 per cycle against threshold 8: fires on the third edge.
    en = 1'b1; threshold = 8'd8; set_cur(3, 0, 0, 0);
    steps("t1", 2);
    check_eq("t1_quiet", 32'(spike), 32'd0);
    step("t1");
    check_eq("t1_third", 32'(spike), 32'b0001);
    steps("t1", 6);

    // Equal strong inputs, hard inhibition: fixed priority then round-robin.
    do_reset();
    en = 1'b1; threshold = 8'd4; hard_inhib = 1'b1; set_cur(5, 5, 5, 5);
    steps("t2fix", 4);
    check_eq("t2_fix_idx", 32'(winner_idx), 32'd0);
    do_reset();
    en = 1'b1; threshold = 8'd4; hard_inhib = 1'b1; rr_mode = 1'b1; set_cur(5, 5, 5, 5);
    steps("t2rr", 4);
    check_eq("t2_rr_idx", 32'(winner_idx), 32'd3);
    step("t2rr");
    check_eq("t2_rr_wrap", 32'(spike), 32'b0001);

    // Soft inhibition leaves neuron 1 at 3, then it wins the next round.
    do_reset();
    en = 1'b1; rr_mode = 1'b1; threshold = 8'd6; inhib_amt = 8'd2; set_cur(6, 5, 0, 0);
    step("t3");
    check_eq("t3_first", 32'(spike), 32'b0001);
    step("t3");
    check_eq("t3_second", 32'(spike), 32'b0010);

    // Refractory period of 3 cycles after each spike.
    do_reset();
    en = 1'b1; threshold = 8'd1; refrac_len = 3'd3; set_cur(15, 0, 0, 0);
    steps("t4", 4);
    check_eq("t4_refrac", 32'(spike), 32'd0);
    step("t4");
    check_eq("t4_refire", 32'(spike), 32'b0001);
    steps("t4", 4);

    // Saturation at 255 then heavy leak without wrap.
    do_reset();
    en = 1'b1; threshold = 8'd255; set_cur(15, 0, 0, 0);
    steps("t5sat", 16);
    check_eq("t5_msb_high", 32'(state_msb), 32'b0001);
    steps("t5sat", 4);
    leak = 8'd200; set_cur(0, 0, 0, 0);
    steps("t5leak", 4);

    // Threshold zero makes every idle neuron a candidate; include a refractory one.
    do_reset();
    en = 1'b1; threshold = 8'd0; rr_mode = 1'b1; refrac_len = 3'd1; set_cur(2, 7, 1, 9);
    steps("t6", 6);
    rr_mode = 1'b0; inhib_amt = 8'd1;
    steps("t6", 4);

    // Freeze with en low, then async reset while a spike is showing.
    do_reset();
    en = 1'b1; threshold = 8'd100; set_cur(0, 1, 0, 0);
    steps("t7", 7);
    en = 1'b0;
    steps("t7hold", 3);
    en = 1'b1; threshold = 8'd8;
    step("t7");
    check_eq("t7_fire", 32'(winner_idx), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t7_async_spike", 32'(spike), 32'd0);
    check_eq("t7_async_valid", 32'(winner_valid), 32'd0);
    check_eq("t7_async_idx", 32'(winner_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    steps("t7post", 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
